// File: rtl/cic_decim_ctrl.sv
// CIC decimator control: sequences integrator enables, decimated comb strobes
// and output-valid gating. The comb chain needs NSTAGES*M decimated samples
// to flush its delay lines before its output is meaningful (PRIME), after
// which every decimated strobe is a valid output (RUN).
module cic_decim_ctrl #(
    parameter int RW      = 8,
    parameter int NSTAGES = 3,
    parameter int M       = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [RW-1:0] i_ratio,
    input  logic          i_ready,
    output logic          o_int_ready,
    output logic          o_dec_strobe,
    output logic          o_out_valid,
    output logic [RW-1:0] o_phase,
    output logic [1:0]    o_state,
    output logic          o_cfg_err
);

    localparam int NPRIME = NSTAGES * M;
    // Wide enough to reach NPRIME itself on the completing pulse.
    localparam int PW     = (NPRIME < 1) ? 1 : $clog2(NPRIME + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRIME = 2'b01,
        RUN   = 2'b10
    } state_t;

    state_t          state;
    logic [RW-1:0]   ratio_q;
    logic [RW-1:0]   phase;
    logic [PW-1:0]   prime_cnt;
    // Set on the edge that accepts the last sample of a decimation period;
    // the strobe itself goes out one cycle later so the comb sees the
    // accumulator after the integrators have absorbed that sample.
    logic            dec_pend;
    logic            wrap;
    logic            last_prime;
    logic            going_run;

    assign wrap       = (phase == ratio_q - RW'(1));
    assign last_prime = (prime_cnt == PW'(NPRIME - 1));
    assign going_run  = (state == PRIME) && o_dec_strobe && last_prime;

    assign o_phase = phase;
    assign o_state = state;

    // Control FSM with all outputs registered; i_en low dominates any sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            ratio_q      <= '0;
            phase        <= '0;
            prime_cnt    <= '0;
            dec_pend     <= 1'b0;
            o_int_ready  <= 1'b0;
            o_dec_strobe <= 1'b0;
            o_out_valid  <= 1'b0;
            o_cfg_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    phase        <= '0;
                    prime_cnt    <= '0;
                    dec_pend     <= 1'b0;
                    o_int_ready  <= 1'b0;
                    o_dec_strobe <= 1'b0;
                    o_out_valid  <= 1'b0;
                    if (i_en) begin
                        if (i_ratio >= RW'(2)) begin
                            ratio_q   <= i_ratio;
                            o_cfg_err <= 1'b0;
                            state     <= PRIME;
                        end else begin
                            o_cfg_err <= 1'b1;
                        end
                    end else begin
                        o_cfg_err <= 1'b0;
                    end
                end
                PRIME, RUN: begin
                    if (!i_en) begin
                        state        <= IDLE;
                        phase        <= '0;
                        prime_cnt    <= '0;
                        dec_pend     <= 1'b0;
                        o_int_ready  <= 1'b0;
                        o_dec_strobe <= 1'b0;
                        o_out_valid  <= 1'b0;
                    end else begin
                        o_int_ready  <= i_ready;
                        dec_pend     <= i_ready && wrap;
                        o_dec_strobe <= dec_pend;
                        o_out_valid  <= dec_pend && ((state == RUN) || going_run);
                        if (i_ready)
                            phase <= wrap ? '0 : phase + RW'(1);
                        if (state == PRIME && o_dec_strobe) begin
                            prime_cnt <= prime_cnt + PW'(1);
                            if (last_prime)
                                state <= RUN;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    phase        <= '0;
                    prime_cnt    <= '0;
                    dec_pend     <= 1'b0;
                    o_int_ready  <= 1'b0;
                    o_dec_strobe <= 1'b0;
                    o_out_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
